// File: rtl/spi_cmd_master_pkg.sv
// Shared opcodes, FSM state encodings and default SPI timing for spi_cmd_master.
package spi_cmd_pkg;

   localparam logic [7:0] OP_TON           = 8'h91;
   localparam logic [7:0] OP_TOFF          = 8'h9E;
   localparam logic [7:0] OP_WAVEFORM      = 8'h9C;
   localparam logic [7:0] OP_IP            = 8'h93;
   localparam logic [7:0] OP_START         = 8'h06;
   localparam logic [7:0] WAVE_SINGLE_TEST = 8'h04;

   localparam int DEF_CS_SETUP_CYC = 5;
   localparam int DEF_HALF_CYC     = 2;
   localparam int DEF_CS_HOLD_CYC  = 5;
   localparam int DEF_GAP_CYC      = 5;

   typedef enum logic [2:0] {
      ST_IDLE, ST_CS_SETUP, ST_BIT_LOW, ST_BIT_HIGH, ST_CS_HOLD, ST_GAP
   } frame_state_t;

   typedef enum logic {CMD_IDLE, CMD_RUN} cmd_state_t;

   function automatic int max4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/spi_cmd_master_if.sv
// Sequencer-side command handshake and receive status for spi_cmd_master.
interface spi_cmd_master_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [7:0]  cmd_opcode;
   logic [15:0] cmd_param;
   logic [1:0]  cmd_len;
   logic        cmd_done;
   logic        busy;
   logic [7:0]  rx_data;
   logic        rx_valid;

   modport master (output cmd_valid, cmd_opcode, cmd_param, cmd_len,
                   input  cmd_ready, cmd_done, busy, rx_data, rx_valid);
   modport slave  (input  cmd_valid, cmd_opcode, cmd_param, cmd_len,
                   output cmd_ready, cmd_done, busy, rx_data, rx_valid);
endinterface

// File: rtl/spi_cmd_master_byte_frame.sv
// One cs_n framed SPI mode-0 byte (MSB first); frames chain back to back when i_start
// is high in the last GAP cycle. MISO capture only with SPI_CMD_MISO_CAPTURE_EN.
module spi_byte_frame
   import spi_cmd_pkg::*;
#(
   parameter int CS_SETUP_CYC = DEF_CS_SETUP_CYC,
   parameter int HALF_CYC     = DEF_HALF_CYC,
   parameter int CS_HOLD_CYC  = DEF_CS_HOLD_CYC,
   parameter int GAP_CYC      = DEF_GAP_CYC
) (
   input  logic       clk_in,
   input  logic       sys_rst_n,
   input  logic       i_start,
   input  logic [7:0] i_byte,
   input  logic       i_miso,
   output logic       o_frame_done,
   output logic       o_cs_n,
   output logic       o_sclk,
   output logic       o_mosi,
   output logic [7:0] o_rx_data,
   output logic       o_rx_valid
);

   localparam int MAX_CYC = max4(CS_SETUP_CYC, HALF_CYC, CS_HOLD_CYC, GAP_CYC);
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);

   frame_state_t     r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [2:0]       r_bit, w_bit_nxt;
   logic [7:0]       r_byte, w_byte_nxt;
   logic             r_cs_n, r_sclk, r_mosi;
   logic             w_cs_n_nxt, w_sclk_nxt, w_mosi_nxt, w_done;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + CNT_W'(1);
      w_bit_nxt   = r_bit;
      w_byte_nxt  = r_byte;
      w_done      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_cnt_nxt = '0;
            if (i_start) begin
               w_state_nxt = ST_CS_SETUP;
               w_byte_nxt  = i_byte;
            end
         end
         ST_CS_SETUP: if (r_cnt == SETUP_LAST) begin
            w_state_nxt = ST_BIT_LOW;
            w_cnt_nxt   = '0;
            w_bit_nxt   = 3'd7;
         end
         ST_BIT_LOW: if (r_cnt == HALF_LAST) begin
            w_state_nxt = ST_BIT_HIGH;
            w_cnt_nxt   = '0;
         end
         ST_BIT_HIGH: if (r_cnt == HALF_LAST) begin
            w_cnt_nxt = '0;
            if (r_bit == 3'd0) w_state_nxt = ST_CS_HOLD;
            else begin
               w_state_nxt = ST_BIT_LOW;
               w_bit_nxt   = r_bit - 3'd1;
            end
         end
         ST_CS_HOLD: if (r_cnt == HOLD_LAST) begin
            w_state_nxt = ST_GAP;
            w_cnt_nxt   = '0;
         end
         ST_GAP: if (r_cnt == GAP_LAST) begin
            w_done    = 1'b1;
            w_cnt_nxt = '0;
            if (i_start) begin
               w_state_nxt = ST_CS_SETUP;
               w_byte_nxt  = i_byte;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
      // Pins are registered from the next state so they change with the state, glitch free.
      w_cs_n_nxt = !(w_state_nxt inside {ST_CS_SETUP, ST_BIT_LOW, ST_BIT_HIGH, ST_CS_HOLD});
      w_sclk_nxt = (w_state_nxt == ST_BIT_HIGH);
      w_mosi_nxt = (w_state_nxt inside {ST_BIT_LOW, ST_BIT_HIGH}) && w_byte_nxt[w_bit_nxt];
   end

   always_ff @(posedge clk_in or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_bit   <= 3'd7;
         r_byte  <= '0;
         r_cs_n  <= 1'b1;
         r_sclk  <= 1'b0;
         r_mosi  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_bit   <= w_bit_nxt;
         r_byte  <= w_byte_nxt;
         r_cs_n  <= w_cs_n_nxt;
         r_sclk  <= w_sclk_nxt;
         r_mosi  <= w_mosi_nxt;
      end
   end

   assign o_frame_done = w_done;
   assign o_cs_n       = r_cs_n;
   assign o_sclk       = r_sclk;
   assign o_mosi       = r_mosi;

`ifdef SPI_CMD_MISO_CAPTURE_EN
   logic [7:0] r_shift, w_shift_nxt, r_rx_data;
   logic       r_rx_valid, w_last_bit;

   // Sample once per bit, in the first sclk-high cycle; the final sample is folded in directly.
   assign w_shift_nxt = (r_state == ST_BIT_HIGH && r_cnt == '0) ? {r_shift[6:0], i_miso} : r_shift;
   assign w_last_bit  = (r_state == ST_BIT_HIGH) && (w_state_nxt == ST_CS_HOLD);

   always_ff @(posedge clk_in or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_shift    <= '0;
         r_rx_data  <= '0;
         r_rx_valid <= 1'b0;
      end else begin
         r_shift    <= w_shift_nxt;
         r_rx_valid <= w_last_bit;
         if (w_last_bit) r_rx_data <= w_shift_nxt;
      end
   end

   assign o_rx_data  = r_rx_data;
   assign o_rx_valid = r_rx_valid;
`else
   logic w_unused_miso;
   assign w_unused_miso = i_miso;
   assign o_rx_data     = '0;
   assign o_rx_valid    = 1'b0;
`endif

endmodule

// File: rtl/spi_cmd_master.sv
// SPI command initiator: latches an opcode + 0..2 parameter bytes and sends each byte
// in its own frame. Optional MISO capture via SPI_CMD_MISO_CAPTURE_EN.
module spi_cmd_master
   import spi_cmd_pkg::*;
#(
   parameter int CS_SETUP_CYC = DEF_CS_SETUP_CYC,
   parameter int HALF_CYC     = DEF_HALF_CYC,
   parameter int CS_HOLD_CYC  = DEF_CS_HOLD_CYC,
   parameter int GAP_CYC      = DEF_GAP_CYC
) (
   input  logic              clk_in,
   input  logic              sys_rst_n,
   spi_cmd_master_if.slave   cmd,
   output logic              cs_n,
   output logic              sclk,
   output logic              mosi,
   input  logic              miso
);

   cmd_state_t  r_state, w_state_nxt;
   logic [15:0] r_param;
   logic [1:0]  r_len, r_idx;
   logic        w_start, w_done, w_frame_done, w_more;
   logic [7:0]  w_byte;

   assign w_more = (r_idx < r_len);

   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_done      = 1'b0;
      w_byte      = cmd.cmd_opcode;
      case (r_state)
         CMD_IDLE: if (cmd.cmd_valid) begin
            w_state_nxt = CMD_RUN;
            w_start     = 1'b1;
         end
         CMD_RUN: if (w_frame_done) begin
            // Next frame starts straight out of this GAP, so the byte is picked for index r_idx+1.
            if (w_more) begin
               w_start = 1'b1;
               w_byte  = (r_idx == 2'd0) ? r_param[7:0] : r_param[15:8];
            end else begin
               w_done      = 1'b1;
               w_state_nxt = CMD_IDLE;
            end
         end
         default: w_state_nxt = CMD_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state <= CMD_IDLE;
         r_param <= '0;
         r_len   <= '0;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == CMD_IDLE && cmd.cmd_valid) begin
            r_param <= cmd.cmd_param;
            r_len   <= (cmd.cmd_len == 2'd3) ? 2'd2 : cmd.cmd_len;
            r_idx   <= '0;
         end else if (r_state == CMD_RUN && w_frame_done && w_more) begin
            r_idx <= r_idx + 2'd1;
         end
      end
   end

   assign cmd.cmd_ready = (r_state == CMD_IDLE);
   assign cmd.busy      = (r_state != CMD_IDLE);
   assign cmd.cmd_done  = w_done;

   spi_byte_frame #(
      .CS_SETUP_CYC (CS_SETUP_CYC),
      .HALF_CYC     (HALF_CYC),
      .CS_HOLD_CYC  (CS_HOLD_CYC),
      .GAP_CYC      (GAP_CYC)
   ) u_frame (
      .clk_in       (clk_in),
      .sys_rst_n    (sys_rst_n),
      .i_start      (w_start),
      .i_byte       (w_byte),
      .i_miso       (miso),
      .o_frame_done (w_frame_done),
      .o_cs_n       (cs_n),
      .o_sclk       (sclk),
      .o_mosi       (mosi),
      .o_rx_data    (cmd.rx_data),
      .o_rx_valid   (cmd.rx_valid)
   );

endmodule
